// File: rtl/control_sequencer.sv
// Instruction sequencer: latches one instruction per handshake into IR, then walks
// IDLE -> T1 [-> T2 -> T3] -> IDLE, decoding register, ALU, PC and immediate
// controls combinationally from the current step and IR.
module control_sequencer #(
  parameter int unsigned NREGS      = 8,
  parameter int unsigned REG_BITS   = 3,
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned IMM_W      = 10,
  parameter bit          IMM_SIGNED = 1'b0
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               instr_ready,
  output logic [NREGS-1:0]   rin,
  output logic [NREGS-1:0]   rout,
  output logic               gin,
  output logic               gout,
  output logic               a_in,
  output logic               addsub,
  output logic               xorctrl,
  output logic               pcin,
  output logic               pcout,
  output logic               ctrl_out,
  output logic [DATA_W-1:0]  imm_out,
  output logic               done,
  output logic               illegal
);

  typedef enum logic [1:0] {StIdle, StT1, StT2, StT3} state_e;

  typedef enum logic [2:0] {
    OpLd   = 3'b000,
    OpMv   = 3'b001,
    OpLdpc = 3'b010,
    OpBr   = 3'b011,
    OpSub  = 3'b100,
    OpAdd  = 3'b101,
    OpXor  = 3'b110,
    OpBad  = 3'b111
  } opcode_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   ir_q;

  opcode_e              opcode;
  logic [REG_BITS-1:0]  rx, ry;
  logic [NREGS-1:0]     rx_oh, ry_oh;
  logic [IMM_W-1:0]     imm_field;
  logic                 is_alu, uses_ry, is_illegal;

  // Field extraction from the latched instruction only; instr_in is never decoded.
  assign opcode    = opcode_e'(ir_q[INSTR_W-1 -: 3]);
  assign rx        = ir_q[INSTR_W-4 -: REG_BITS];
  assign ry        = ir_q[INSTR_W-4-REG_BITS -: REG_BITS];
  assign imm_field = ir_q[IMM_W-1:0];
  assign rx_oh     = NREGS'(1) << rx;
  assign ry_oh     = NREGS'(1) << ry;

  assign is_alu     = (opcode == OpSub) || (opcode == OpAdd) || (opcode == OpXor);
  assign uses_ry    = is_alu || (opcode == OpMv);
  // Out-of-range register indices are only illegal where the opcode actually uses them.
  assign is_illegal = (opcode == OpBad) || (32'(rx) >= NREGS) ||
                      (uses_ry && (32'(ry) >= NREGS));

  assign imm_out = IMM_SIGNED ? DATA_W'($signed(imm_field)) : DATA_W'(imm_field);

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Instruction register: loads only on an accepted handshake in IDLE.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      ir_q <= '0;
    end else if ((state_q == StIdle) && instr_valid) begin
      ir_q <= instr_in;
    end
  end

  // Next-state: ALU instructions take three steps, everything else one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (instr_valid) state_d = StT1;
      StT1:    state_d = (is_alu && !is_illegal) ? StT2 : StIdle;
      StT2:    state_d = StT3;
      StT3:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from current step and IR.
  always_comb begin
    instr_ready = 1'b0;
    rin         = '0;
    rout        = '0;
    gin         = 1'b0;
    gout        = 1'b0;
    a_in        = 1'b0;
    addsub      = 1'b0;
    xorctrl     = 1'b0;
    pcin        = 1'b0;
    pcout       = 1'b0;
    ctrl_out    = 1'b0;
    done        = 1'b0;
    illegal     = 1'b0;
    unique case (state_q)
      StIdle: instr_ready = 1'b1;
      StT1: begin
        if (is_illegal) begin
          done    = 1'b1;
          illegal = 1'b1;
        end else begin
          unique case (opcode)
            OpLd: begin
              rin      = rx_oh;
              ctrl_out = 1'b1;
              done     = 1'b1;
            end
            OpMv: begin
              rin  = rx_oh;
              rout = ry_oh;
              done = 1'b1;
            end
            OpLdpc: begin
              rin   = rx_oh;
              pcout = 1'b1;
              done  = 1'b1;
            end
            OpBr: begin
              rout = rx_oh;
              pcin = 1'b1;
              done = 1'b1;
            end
            OpSub, OpAdd, OpXor: begin
              rout = rx_oh;
              a_in = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StT2: begin
        rout    = ry_oh;
        gin     = 1'b1;
        addsub  = (opcode == OpSub);
        xorctrl = (opcode == OpXor);
      end
      StT3: begin
        gout = 1'b1;
        rin  = rx_oh;
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a step-list model predicts every output cycle of the
// 8-register DUT; literal pins fix selected cycles on it and on a 6-register,
// sign-extending instance.
module tb_control_sequencer;

  typedef struct packed {
    logic        ready;
    logic [7:0]  rin;
    logic [7:0]  rout;
    logic [9:0]  flags; // gin gout a_in addsub xorctrl pcin pcout ctrl_out done illegal
    logic [15:0] imm;
  } ovec_t;

  localparam logic [9:0] F_GIN   = 10'b1000000000;
  localparam logic [9:0] F_GOUT  = 10'b0100000000;
  localparam logic [9:0] F_AIN   = 10'b0010000000;
  localparam logic [9:0] F_SUB   = 10'b0001000000;
  localparam logic [9:0] F_XOR   = 10'b0000100000;
  localparam logic [9:0] F_PCIN  = 10'b0000010000;
  localparam logic [9:0] F_PCOUT = 10'b0000001000;
  localparam logic [9:0] F_CTRL  = 10'b0000000100;
  localparam logic [9:0] F_DONE  = 10'b0000000010;
  localparam logic [9:0] F_ILL   = 10'b0000000001;

  logic        clock = 1'b0;
  logic        resetn;
  logic        instr_valid, instr_valid2;
  logic [15:0] instr_in, instr_in2;

  logic        instr_ready, gin, gout, a_in, addsub, xorctrl, pcin, pcout, ctrl_out;
  logic        done, illegal;
  logic [7:0]  rin, rout;
  logic [15:0] imm_out;

  logic        instr_ready2, gin2, gout2, a_in2, addsub2, xorctrl2, pcin2, pcout2;
  logic        ctrl_out2, done2, illegal2;
  logic [5:0]  rin2, rout2;
  logic [15:0] imm_out2;

  always #5 clock = ~clock;

  control_sequencer dut (
    .clock(clock), .resetn(resetn), .instr_valid(instr_valid), .instr_in(instr_in),
    .instr_ready(instr_ready), .rin(rin), .rout(rout), .gin(gin), .gout(gout),
    .a_in(a_in), .addsub(addsub), .xorctrl(xorctrl), .pcin(pcin), .pcout(pcout),
    .ctrl_out(ctrl_out), .imm_out(imm_out), .done(done), .illegal(illegal)
  );

  control_sequencer #(.NREGS(6), .IMM_SIGNED(1'b1)) dut2 (
    .clock(clock), .resetn(resetn), .instr_valid(instr_valid2), .instr_in(instr_in2),
    .instr_ready(instr_ready2), .rin(rin2), .rout(rout2), .gin(gin2), .gout(gout2),
    .a_in(a_in2), .addsub(addsub2), .xorctrl(xorctrl2), .pcin(pcin2), .pcout(pcout2),
    .ctrl_out(ctrl_out2), .imm_out(imm_out2), .done(done2), .illegal(illegal2)
  );

  function automatic ovec_t mk(input logic rdy, input logic [7:0] ri, input logic [7:0] ro,
                               input logic [9:0] fl, input logic [15:0] im);
    ovec_t v;
    v.ready = rdy; v.rin = ri; v.rout = ro; v.flags = fl; v.imm = im;
    return v;
  endfunction

  function automatic ovec_t dut_vec();
    return mk(instr_ready, rin, rout,
              {gin, gout, a_in, addsub, xorctrl, pcin, pcout, ctrl_out, done, illegal}, imm_out);
  endfunction

  function automatic ovec_t dut2_vec();
    return mk(instr_ready2, {2'b00, rin2}, {2'b00, rout2},
              {gin2, gout2, a_in2, addsub2, xorctrl2, pcin2, pcout2, ctrl_out2, done2, illegal2},
              imm_out2);
  endfunction

  // Pinned literal expectations, read by the compare process at cycle pin*_cyc.
  int    cyc = 0;
  int    pin_cyc = -1, pin2_cyc = -1;
  string pin_name, pin2_name;
  ovec_t pin_exp, pin2_exp;

  int n_vec = 0;
  int n_miss = 0;

  // Model: an accepted instruction becomes a list of per-cycle output records.
  ovec_t       exp_q[$];
  logic [15:0] ir_m = '0;
  ovec_t       cur;

  function automatic logic [15:0] zext(input logic [15:0] ins);
    return {6'b0, ins[9:0]};
  endfunction

  task automatic push_steps(input logic [15:0] ins);
    int op, x, y;
    logic [15:0] im;
    op = int'(ins[15:13]);
    x  = int'(ins[12:10]);
    y  = int'(ins[9:7]);
    im = zext(ins);
    case (op)
      0: exp_q.push_back(mk(0, 8'(1 << x), 8'h00, F_CTRL | F_DONE, im));
      1: exp_q.push_back(mk(0, 8'(1 << x), 8'(1 << y), F_DONE, im));
      2: exp_q.push_back(mk(0, 8'(1 << x), 8'h00, F_PCOUT | F_DONE, im));
      3: exp_q.push_back(mk(0, 8'h00, 8'(1 << x), F_PCIN | F_DONE, im));
      4, 5, 6: begin
        exp_q.push_back(mk(0, 8'h00, 8'(1 << x), F_AIN, im));
        exp_q.push_back(mk(0, 8'h00, 8'(1 << y),
                           F_GIN | (op == 4 ? F_SUB : 10'd0) | (op == 6 ? F_XOR : 10'd0), im));
        exp_q.push_back(mk(0, 8'(1 << x), 8'h00, F_GOUT | F_DONE, im));
      end
      default: exp_q.push_back(mk(0, 8'h00, 8'h00, F_DONE | F_ILL, im));
    endcase
  endtask

  task automatic compare(input string name, input ovec_t got, input ovec_t exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got rdy=%b rin=%h rout=%h flags=%b imm=%h, want rdy=%b rin=%h rout=%h flags=%b imm=%h",
               name, cyc, got.ready, got.rin, got.rout, got.flags, got.imm,
               exp.ready, exp.rin, exp.rout, exp.flags, exp.imm);
    end
  endtask

  // Model update at each rising edge, all comparisons at the following falling edge.
  initial begin
    forever begin
      @(posedge clock);
      if (!resetn) begin
        exp_q.delete();
        ir_m = '0;
      end else if (exp_q.size() != 0) begin
        void'(exp_q.pop_front());
      end else if (instr_valid) begin
        ir_m = instr_in;
        push_steps(instr_in);
      end
      cur = (exp_q.size() != 0) ? exp_q[0] : mk(1, 8'h00, 8'h00, 10'd0, zext(ir_m));
      @(negedge clock);
      compare("model", dut_vec(), cur);
      if (pin_cyc == cyc) compare(pin_name, dut_vec(), pin_exp);
      if (pin2_cyc == cyc) compare(pin2_name, dut2_vec(), pin2_exp);
      cyc++;
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic pin(input string name, input ovec_t e);
    pin_name = name; pin_exp = e; pin_cyc = cyc;
  endtask

  task automatic pin2(input string name, input ovec_t e);
    pin2_name = name; pin2_exp = e; pin2_cyc = cyc;
  endtask

  task automatic one_shot(input logic [15:0] ins);
    instr_valid = 1'b1; instr_in = ins;
    step();
    instr_valid = 1'b0; instr_in = 16'($urandom);
    step();
  endtask

  initial begin
    resetn = 1'b0; instr_valid = 1'b0; instr_in = '0; instr_valid2 = 1'b0; instr_in2 = '0;
    step(); step();
    resetn = 1'b1;
    pin("reset_idle", mk(1, 8'h00, 8'h00, 10'd0, 16'h0000));
    pin2("reset_idle2", mk(1, 8'h00, 8'h00, 10'd0, 16'h0000));
    step();

    // LD r5, 0x3FF
    instr_valid = 1'b1; instr_in = 16'h17FF;
    pin("ld_t1", mk(0, 8'h20, 8'h00, F_CTRL | F_DONE, 16'h03FF));
    step();
    instr_valid = 1'b0; instr_in = 16'($urandom);
    pin("ld_idle", mk(1, 8'h00, 8'h00, 10'd0, 16'h03FF));
    step();

    // MV r2 <- r6
    instr_valid = 1'b1; instr_in = 16'h2B00;
    pin("mv_t1", mk(0, 8'h04, 8'h40, F_DONE, 16'h0300));
    step();
    instr_valid = 1'b0; instr_in = 16'($urandom);
    pin("mv_idle", mk(1, 8'h00, 8'h00, 10'd0, 16'h0300));
    step();

    // SUB r1, r3
    instr_valid = 1'b1; instr_in = 16'h8580;
    pin("sub_t1", mk(0, 8'h00, 8'h02, F_AIN, 16'h0180));
    step();
    instr_valid = 1'b0; instr_in = 16'($urandom);
    pin("sub_t2", mk(0, 8'h00, 8'h08, F_GIN | F_SUB, 16'h0180));
    step();
    pin("sub_t3", mk(0, 8'h02, 8'h00, F_GOUT | F_DONE, 16'h0180));
    step();
    pin("sub_idle", mk(1, 8'h00, 8'h00, 10'd0, 16'h0180));
    step();

    // LDPC r3, BR r4, MV r5 <- r5
    one_shot(16'h4C07);
    one_shot(16'h7000);
    one_shot(16'h3680);

    // Opcode 111
    instr_valid = 1'b1; instr_in = 16'hE000;
    pin("op111", mk(0, 8'h00, 8'h00, F_DONE | F_ILL, 16'h0000));
    step();
    instr_valid = 1'b0;
    step();

    // XOR r2, r3 with valid held and instr_in changed mid-instruction
    instr_valid = 1'b1; instr_in = 16'hC980;
    pin("xor_t1", mk(0, 8'h00, 8'h04, F_AIN, 16'h0180));
    step();
    instr_in = 16'h0405;
    pin("xor_t2", mk(0, 8'h00, 8'h08, F_GIN | F_XOR, 16'h0180));
    step();
    pin("xor_t3", mk(0, 8'h04, 8'h00, F_GOUT | F_DONE, 16'h0180));
    step();
    pin("xor_idle", mk(1, 8'h00, 8'h00, 10'd0, 16'h0180));
    step();
    pin("ld_after_xor", mk(0, 8'h02, 8'h00, F_CTRL | F_DONE, 16'h0005));
    step();
    instr_valid = 1'b0;
    step();

    // Reset during ADD r4, r5 T2, held for two edges
    instr_valid = 1'b1; instr_in = 16'hB280;
    step();
    instr_valid = 1'b0;
    pin("add_t2", mk(0, 8'h00, 8'h20, F_GIN, 16'h0280));
    step();
    resetn = 1'b0;
    pin("rst_mid", mk(1, 8'h00, 8'h00, 10'd0, 16'h0000));
    step();
    step();
    resetn = 1'b1;
    pin("rst_after", mk(1, 8'h00, 8'h00, 10'd0, 16'h0000));
    step();

    // Six-register, sign-extending instance
    instr_valid2 = 1'b1; instr_in2 = 16'h1600;
    pin2("n6_ld_r5", mk(0, 8'h20, 8'h00, F_CTRL | F_DONE, 16'hFE00));
    step();
    instr_valid2 = 1'b0;
    step();
    instr_valid2 = 1'b1; instr_in2 = 16'h1C00;
    pin2("n6_ld_r7", mk(0, 8'h00, 8'h00, F_DONE | F_ILL, 16'h0000));
    step();
    instr_valid2 = 1'b0;
    step();
    instr_valid2 = 1'b1; instr_in2 = 16'h2780;
    pin2("n6_mv_ry7", mk(0, 8'h00, 8'h00, F_DONE | F_ILL, 16'hFF80));
    step();
    instr_valid2 = 1'b0;
    pin2("n6_idle", mk(1, 8'h00, 8'h00, 10'd0, 16'hFF80));
    step();

    // Mixed traffic checked by the model alone
    for (int i = 0; i < 40; i++) begin
      instr_valid = 1'($urandom_range(0, 1));
      instr_in    = 16'($urandom);
      step();
    end
    instr_valid = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
